// File: rtl/mon_sopc_boutons.sv
// Avalon-MM push-button/switch input PIO: synchronised level, per-bit edge capture, maskable level irq.
// Optional debounce filter enabled by defining PIO_DEBOUNCE_EN.
module mon_sopc_boutons #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_RSVD = 2'd1,
        REG_MASK = 2'd2,
        REG_EDGE = 2'd3
    } reg_addr_e;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_event;
    logic [WIDTH-1:0] wr_bits;
    logic [WIDTH-1:0] clear_bits;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wr_bits      = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= in_port;
            s2   <= s1;
            prev <= lvl;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt [WIDTH];

    // NOTE: the counter array is plain per-bit flops, so it is reset with the rest of the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    lvl[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    logic unused_debounce;
    assign unused_debounce = (DEBOUNCE_CYCLES == 0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl <= '0;
        end else begin
            lvl <= s2;
        end
    end
`endif

    // NOTE: defaults first in every always_comb so no path leaves a variable unassigned (no latch).
    always_comb begin
        edge_event = lvl ^ prev;
        case (EDGE_TYPE)
            0:       edge_event = lvl & ~prev;
            1:       edge_event = ~lvl & prev;
            default: edge_event = lvl ^ prev;
        endcase
    end

    assign clear_bits = (wr_en && (address == REG_EDGE)) ? wr_bits : '0;

    // A new event wins over a simultaneous W1C on the same bit, so no event is ever dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~clear_bits) | edge_event;
            if (wr_en && (address == REG_MASK)) begin
                irq_mask <= wr_bits;
            end
        end
    end

    assign irq = |(edge_capture & irq_mask);

    always_comb begin
        readdata = '0;
        case (address)
            REG_DATA: readdata = 32'(lvl);
            REG_RSVD: readdata = '0;
            REG_MASK: readdata = 32'(irq_mask);
            REG_EDGE: readdata = 32'(edge_capture);
            default:  readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_mon_sopc_boutons.sv
// Bench for mon_sopc_boutons: three instances (rise/fall/any) against a delay-line model plus directed checks.
module tb_mon_sopc_boutons;

    localparam int W  = 4;
    localparam int DB = 8;
`ifdef PIO_DEBOUNCE_EN
    localparam int EXTRA   = DB - 1;
    localparam int CHG_MOD = 32;
`else
    localparam int EXTRA   = 0;
    localparam int CHG_MOD = 4;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [W-1:0]  in_port = '1;
    logic [31:0]   rd0, rd1, rd2;
    logic          irq0, irq1, irq2;

    int tests = 0;
    int fails = 0;

    mon_sopc_boutons #(.WIDTH(W), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DB)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0));
    mon_sopc_boutons #(.WIDTH(W), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(DB)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd1), .irq(irq1));
    mon_sopc_boutons #(.WIDTH(W), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DB)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_of(input int t);
        case (t)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    function automatic logic irq_of(input int t);
        case (t)
            0:       return irq0;
            1:       return irq1;
            default: return irq2;
        endcase
    endfunction

    // Model: the input level reaches DATA two clocks after it is sampled; events compare
    // successive DATA values; W1C and mask writes act at the write edge.
    logic [W-1:0] h0, h1;
    logic [W-1:0] m_lvl, m_prev, m_mask;
    logic [W-1:0] m_cap [3];
    int           run [W];

    function automatic logic [W-1:0] ev(input int t, input logic [W-1:0] cur, input logic [W-1:0] old);
        case (t)
            0:       return cur & ~old;
            1:       return ~cur & old;
            default: return cur ^ old;
        endcase
    endfunction

    task automatic model_step();
        logic [W-1:0] s2_now;
        logic [W-1:0] wb;
        logic         wr;
        if (!reset_n) begin
            h0 = '0; h1 = '0; m_lvl = '0; m_prev = '0; m_mask = '0;
            for (int t = 0; t < 3; t++) m_cap[t] = '0;
            for (int i = 0; i < W; i++) run[i] = 0;
        end else begin
            s2_now = h1;
            wb = writedata[W-1:0];
            wr = chipselect && !write_n;
            for (int t = 0; t < 3; t++)
                m_cap[t] = (m_cap[t] & ~((wr && address == 2'd3) ? wb : '0)) | ev(t, m_lvl, m_prev);
            if (wr && address == 2'd2) m_mask = wb;
            m_prev = m_lvl;
`ifdef PIO_DEBOUNCE_EN
            for (int i = 0; i < W; i++) begin
                run[i] = (s2_now[i] != m_lvl[i]) ? run[i] + 1 : 0;
                if (run[i] == DB) begin
                    m_lvl[i] = s2_now[i];
                    run[i] = 0;
                end
            end
`else
            m_lvl = s2_now;
`endif
            h1 = h0;
            h0 = in_port;
        end
    endtask

    task automatic compare();
        logic [31:0] exp;
        for (int t = 0; t < 3; t++) begin
            case (address)
                2'd0:    exp = 32'(m_lvl);
                2'd2:    exp = 32'(m_mask);
                2'd3:    exp = 32'(m_cap[t]);
                default: exp = '0;
            endcase
            check($sformatf("model_rd_t%0d_a%0d", t, address), rd_of(t), exp);
            check($sformatf("model_irq_t%0d", t), 32'(irq_of(t)), 32'(|(m_cap[t] & m_mask)));
        end
    endtask

    always begin
        @(posedge clk);
        model_step();
        #1;
        compare();
    end

    // Directed helpers: all driving happens on the falling edge.
    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic rd_chk(input string name, input int t, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(name, rd_of(t), exp);
    endtask

    task automatic irq_chk(input string name, input int t, input logic exp);
        check(name, 32'(irq_of(t)), 32'(exp));
    endtask

    initial begin
        // 1: reset with inputs high, DATA follows three clocks after release
        repeat (3) @(negedge clk);
        rd_chk("rst_data", 1, 2'd0, 32'h0);
        irq_chk("rst_irq", 1, 1'b0);
        rd_chk("rst_cap", 1, 2'd3, 32'h0);
        reset_n = 1'b1;
        repeat (3 + EXTRA) @(negedge clk);
        rd_chk("t1_data", 1, 2'd0, 32'h0000000F);
        irq_chk("t1_irq", 1, 1'b0);
        rd_chk("t1_cap", 1, 2'd3, 32'h0);

        // 2: masked falling edge on bit 0, then W1C
        wr_reg(2'd2, 32'h1);
        in_port[0] = 1'b0;
        repeat (3 + EXTRA) @(negedge clk);
        rd_chk("t2_data_k2", 1, 2'd0, 32'hE);
        rd_chk("t2_cap_k2", 1, 2'd3, 32'h0);
        @(negedge clk);
        rd_chk("t2_cap_k3", 1, 2'd3, 32'h1);
        irq_chk("t2_irq_k3", 1, 1'b1);
        wr_reg(2'd3, 32'h1);
        rd_chk("t2_cap_clr", 1, 2'd3, 32'h0);
        irq_chk("t2_irq_clr", 1, 1'b0);

        // 3: unmasked event, then mask enables irq on the next cycle
        wr_reg(2'd2, 32'h0);
        in_port[2] = 1'b0;
        repeat (4 + EXTRA) @(negedge clk);
        rd_chk("t3_cap", 1, 2'd3, 32'h4);
        irq_chk("t3_irq_masked", 1, 1'b0);
        wr_reg(2'd2, 32'hFFFF_FFF4);
        irq_chk("t3_irq_unmasked", 1, 1'b1);
        rd_chk("t3_mask_width", 1, 2'd2, 32'h4);
        wr_reg(2'd3, 32'h4);
        irq_chk("t3_irq_clr", 1, 1'b0);

        // 4: event on bit 1 lands on the same edge as its W1C: set wins
        in_port[1] = 1'b0;
        repeat (3 + EXTRA) @(negedge clk);
        wr_reg(2'd3, 32'h2);
        rd_chk("t4_set_wins", 1, 2'd3, 32'h2);
        wr_reg(2'd3, 32'h2);
        rd_chk("t4_clear", 1, 2'd3, 32'h0);

        // 5: mid-cycle reset clears pending events and mask at once
        in_port = '1;
        repeat (5 + EXTRA) @(negedge clk);
        in_port = '0;
        repeat (5 + EXTRA) @(negedge clk);
        wr_reg(2'd2, 32'hF);
        rd_chk("t5_cap_full", 1, 2'd3, 32'hF);
        irq_chk("t5_irq_full", 1, 1'b1);
        in_port = '1;
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_cap_rst", rd1, 32'h0);
        irq_chk("t5_irq_rst", 1, 1'b0);
        address = 2'd2;
        #1;
        check("t5_mask_rst", rd1, 32'h0);
        check("t5_mask_rst_any", rd2, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6 + EXTRA) @(negedge clk);
        rd_chk("t5_fall_nocap", 1, 2'd3, 32'h0);
        rd_chk("t5_rise_cap", 0, 2'd3, 32'hF);
        rd_chk("t5_any_cap", 2, 2'd3, 32'hF);

`ifdef PIO_DEBOUNCE_EN
        // 6: short glitch filtered, long low accepted
        in_port[3] = 1'b0;
        repeat (5) @(negedge clk);
        in_port[3] = 1'b1;
        repeat (DB + 6) @(negedge clk);
        rd_chk("t6_glitch_data", 1, 2'd0, 32'hF);
        rd_chk("t6_glitch_cap", 1, 2'd3, 32'h0);
        in_port[3] = 1'b0;
        repeat (20) @(negedge clk);
        rd_chk("t6_long_data", 1, 2'd0, 32'h7);
        rd_chk("t6_long_cap", 1, 2'd3, 32'h8);
`endif

        // Randomized traffic, checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(CHG_MOD - 1) == 0) in_port = W'($urandom);
            if ($urandom_range(3) == 0) begin
                chipselect = 1'b1;
                write_n    = 1'($urandom_range(1));
                writedata  = $urandom;
            end else begin
                chipselect = 1'($urandom_range(1));
                write_n    = 1'b1;
                writedata  = $urandom;
            end
            address = 2'($urandom_range(3));
            reset_n = ($urandom_range(599) != 0);
            @(negedge clk);
        end
        reset_n = 1'b1;
        chipselect = 1'b0;
        write_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
